// File: rtl/clock_pkg.sv
// Shared types and constants for the VGA clock timekeeping block.
// Provides the alarm state encoding, the register widths, the event indices
// used by the scheduler, and a wrapping-increment helper.
package clock_pkg;

  // Widths of the hour and minute/second registers
  localparam int unsigned HR_W = 4;
  localparam int unsigned MS_W = 6;

  // Event indices. A lower index has higher scheduling priority.
  localparam int unsigned EV_N    = 6;
  localparam int unsigned EV_TICK = 0;
  localparam int unsigned EV_SEC  = 1;
  localparam int unsigned EV_MIN  = 2;
  localparam int unsigned EV_HRS  = 3;
  localparam int unsigned EV_AL   = 4;
  localparam int unsigned EV_TOG  = 5;

  localparam logic [MS_W-1:0] SIXTY = MS_W'(60);

  typedef enum logic [1:0] {
    AL_DISARMED = 2'd0,
    AL_ARMED    = 2'd1,
    AL_RINGING  = 2'd2,
    AL_SILENCED = 2'd3
  } al_state_t;

  // v + 1 modulo 'modulus'; any value at or above modulus-1 wraps to 0
  function automatic logic [MS_W-1:0] inc_wrap(input logic [MS_W-1:0] v,
                                               input logic [MS_W-1:0] modulus);
    return (v >= modulus - MS_W'(1)) ? '0 : v + MS_W'(1);
  endfunction

endpackage

// File: rtl/event_arbiter.sv
// Pending-flag latch and fixed-priority scheduler for the clock events.
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset
//   ev_in         - one-cycle event pulses, indexed by EV_*
//   grant_c       - one-hot grant of the highest-priority pending flag (combinational)
//   evt_overrun   - one-cycle pulse when an event arrives on a busy flag
module event_arbiter
  import clock_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [EV_N-1:0] ev_in,
  output logic [EV_N-1:0] grant_c,
  output logic            evt_overrun
);

  logic [EV_N-1:0] pend;
  logic [EV_N-1:0] pend_nxt;
  logic            drop_c;

  // Lowest set bit wins; a re-arriving event on its granted flag keeps the flag set
  always_comb begin
    grant_c  = pend & (~pend + EV_N'(1));
    pend_nxt = ev_in | (pend & ~grant_c);
    drop_c   = |(ev_in & pend & ~grant_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend        <= '0;
      evt_overrun <= 1'b0;
    end else begin
      pend        <= pend_nxt;
      evt_overrun <= drop_c;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and alarm sequencer for the VGA clock.
// Owns the time and alarm registers, applies at most one scheduled update per
// cycle, and runs the alarm state machine that drives the bell and buzzer.
// Ports:
//   clk, reset_n                - 31.5 MHz clock, asynchronous active-low reset
//   tick_1hz                    - 1 Hz one-cycle tick
//   sec_adj/min_adj/hrs_adj     - debounced time adjust pulses
//   al_adj, al_toggle           - alarm +AL_STEP minutes, arm/disarm
//   hours/minutes/seconds       - current time
//   al_hours/al_minutes         - alarm time
//   al_on, buzzer_en            - bell icon enable, buzzer enable
//   evt_overrun                 - one-cycle pulse when an event was dropped
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOURS_MOD    = 12,
  parameter int unsigned AL_STEP      = 10,
  parameter int unsigned RING_SECONDS = 60
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tick_1hz,
  input  logic            sec_adj,
  input  logic            min_adj,
  input  logic            hrs_adj,
  input  logic            al_adj,
  input  logic            al_toggle,
  output logic [HR_W-1:0] hours,
  output logic [MS_W-1:0] minutes,
  output logic [MS_W-1:0] seconds,
  output logic [HR_W-1:0] al_hours,
  output logic [MS_W-1:0] al_minutes,
  output logic            al_on,
  output logic            buzzer_en,
  output logic            evt_overrun
);

  localparam int unsigned RC_W = $clog2(RING_SECONDS + 1);
  localparam logic [MS_W:0] AL_STEP_W = (MS_W + 1)'(AL_STEP);
  localparam logic [MS_W:0] SIXTY_W   = {1'b0, SIXTY};

  logic [EV_N-1:0] ev_in;
  logic [EV_N-1:0] grant_c;

  logic [HR_W-1:0] hours_nxt;
  logic [MS_W-1:0] minutes_nxt;
  logic [MS_W-1:0] seconds_nxt;
  logic [HR_W-1:0] al_hours_nxt;
  logic [MS_W-1:0] al_minutes_nxt;
  logic [MS_W:0]   al_sum;

  al_state_t       state;
  al_state_t       state_nxt;
  logic [RC_W-1:0] ring_cnt;
  logic [RC_W-1:0] ring_cnt_nxt;
  logic            match_c;

  function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] h);
    return HR_W'(inc_wrap(MS_W'(h), MS_W'(HOURS_MOD)));
  endfunction

  assign ev_in = {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, tick_1hz};

  event_arbiter u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .ev_in       (ev_in),
    .grant_c     (grant_c),
    .evt_overrun (evt_overrun)
  );

  // Next time/alarm values from the single granted event
  always_comb begin
    hours_nxt      = hours;
    minutes_nxt    = minutes;
    seconds_nxt    = seconds;
    al_hours_nxt   = al_hours;
    al_minutes_nxt = al_minutes;
    al_sum         = {1'b0, al_minutes} + AL_STEP_W;

    if (grant_c[EV_TICK]) begin
      if (seconds >= SIXTY - MS_W'(1)) begin
        seconds_nxt = '0;
        if (minutes >= SIXTY - MS_W'(1)) begin
          minutes_nxt = '0;
          hours_nxt   = hr_inc(hours);
        end else begin
          minutes_nxt = minutes + MS_W'(1);
        end
      end else begin
        seconds_nxt = seconds + MS_W'(1);
      end
    end else if (grant_c[EV_SEC]) begin
      seconds_nxt = inc_wrap(seconds, SIXTY);
    end else if (grant_c[EV_MIN]) begin
      minutes_nxt = inc_wrap(minutes, SIXTY);
    end else if (grant_c[EV_HRS]) begin
      hours_nxt = hr_inc(hours);
    end else if (grant_c[EV_AL]) begin
      // Sum is one bit wider so 59 + step cannot overflow before the wrap
      if (al_sum >= SIXTY_W) begin
        al_minutes_nxt = MS_W'(al_sum - SIXTY_W);
        al_hours_nxt   = hr_inc(al_hours);
      end else begin
        al_minutes_nxt = MS_W'(al_sum);
      end
    end
  end

  assign match_c = (hours == al_hours) && (minutes == al_minutes);

  // Alarm state machine; a toggle always wins over match or ring timeout
  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    case (state)
      AL_DISARMED: begin
        if (grant_c[EV_TOG]) state_nxt = AL_ARMED;
      end
      AL_ARMED: begin
        if (grant_c[EV_TOG]) begin
          state_nxt = AL_DISARMED;
        end else if (match_c) begin
          state_nxt    = AL_RINGING;
          ring_cnt_nxt = '0;
        end
      end
      AL_RINGING: begin
        if (grant_c[EV_TOG]) begin
          state_nxt = AL_DISARMED;
        end else if (ring_cnt >= RC_W'(RING_SECONDS)) begin
          state_nxt = AL_SILENCED;
        end else if (grant_c[EV_TICK]) begin
          ring_cnt_nxt = ring_cnt + RC_W'(1);
        end
      end
      AL_SILENCED: begin
        // Wait for the alarm minute to pass so the same minute cannot re-trigger
        if (grant_c[EV_TOG]) begin
          state_nxt = AL_DISARMED;
        end else if (!match_c) begin
          state_nxt = AL_ARMED;
        end
      end
      default: state_nxt = AL_DISARMED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hours      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      al_hours   <= '0;
      al_minutes <= '0;
      state      <= AL_DISARMED;
      ring_cnt   <= '0;
      al_on      <= 1'b0;
      buzzer_en  <= 1'b0;
    end else begin
      hours      <= hours_nxt;
      minutes    <= minutes_nxt;
      seconds    <= seconds_nxt;
      al_hours   <= al_hours_nxt;
      al_minutes <= al_minutes_nxt;
      state      <= state_nxt;
      ring_cnt   <= ring_cnt_nxt;
      al_on      <= (state_nxt != AL_DISARMED);
      buzzer_en  <= (state_nxt == AL_RINGING);
    end
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl with a time/alarm scoreboard.
module tb_clock_time_ctrl;
  import clock_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_1hz = 1'b0, sec_adj = 1'b0, min_adj = 1'b0, hrs_adj = 1'b0;
  logic       al_adj = 1'b0, al_toggle = 1'b0;
  logic [3:0] hours, al_hours;
  logic [5:0] minutes, seconds, al_minutes;
  logic       al_on, buzzer_en, evt_overrun;

  clock_time_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_1hz    (tick_1hz),
    .sec_adj     (sec_adj),
    .min_adj     (min_adj),
    .hrs_adj     (hrs_adj),
    .al_adj      (al_adj),
    .al_toggle   (al_toggle),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .al_hours    (al_hours),
    .al_minutes  (al_minutes),
    .al_on       (al_on),
    .buzzer_en   (buzzer_en),
    .evt_overrun (evt_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int h;
    int m;
    int s;
    int ah;
    int am;
  } snap_t;

  snap_t sb[$];
  int m_h, m_m, m_s, m_ah, m_am;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference time model, one event at a time
  task automatic m_apply(input int ev);
    case (ev)
      0: begin
        if (m_s == 59) begin
          m_s = 0;
          if (m_m == 59) begin
            m_m = 0;
            m_h = (m_h + 1) % 12;
          end else m_m++;
        end else m_s++;
      end
      1: m_s = (m_s + 1) % 60;
      2: m_m = (m_m + 1) % 60;
      3: m_h = (m_h + 1) % 12;
      4: begin
        m_am += 10;
        if (m_am >= 60) begin
          m_am -= 60;
          m_ah = (m_ah + 1) % 12;
        end
      end
      default: ;
    endcase
    sb.push_back('{h: m_h, m: m_m, s: m_s, ah: m_ah, am: m_am});
  endtask

  task automatic pop_cmp(input string tag);
    snap_t e;
    check({tag, "_sbq"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_hrs"}, 32'(hours), e.h);
      check({tag, "_min"}, 32'(minutes), e.m);
      check({tag, "_sec"}, 32'(seconds), e.s);
      check({tag, "_alh"}, 32'(al_hours), e.ah);
      check({tag, "_alm"}, 32'(al_minutes), e.am);
    end
  endtask

  task automatic set_ev(input int ev, input logic v);
    case (ev)
      0: tick_1hz  = v;
      1: sec_adj   = v;
      2: min_adj   = v;
      3: hrs_adj   = v;
      4: al_adj    = v;
      default: al_toggle = v;
    endcase
  endtask

  // Called at posedge+1; one-cycle pulse, result checked after the commit edge
  task automatic pulse(input int ev, input string tag);
    set_ev(ev, 1'b1);
    m_apply(ev);
    @(posedge clk); #1;
    set_ev(ev, 1'b0);
    @(posedge clk); #1;
    pop_cmp(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) set_ev(i, 1'b0);
    m_h = 0; m_m = 0; m_s = 0; m_ah = 0; m_am = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int ov_cnt;

  initial begin
    // Reset state
    do_reset();
    check("rst_hrs", 32'(hours), 0);
    check("rst_min", 32'(minutes), 0);
    check("rst_sec", 32'(seconds), 0);
    check("rst_alh", 32'(al_hours), 0);
    check("rst_alm", 32'(al_minutes), 0);
    check("rst_alon", 32'(al_on), 0);
    check("rst_buz", 32'(buzzer_en), 0);
    check("rst_ovr", 32'(evt_overrun), 0);

    // First tick
    pulse(0, "tick1");
    check("tick1_sec1", 32'(seconds), 1);
    check("tick1_alon", 32'(al_on), 0);

    // 11:59:59 rollover
    do_reset();
    repeat (11) pulse(3, "pre_h");
    repeat (59) pulse(2, "pre_m");
    repeat (59) pulse(1, "pre_s");
    check("pre_1159", 32'(hours * 100 + minutes), 1159);
    pulse(0, "rollover");
    check("roll_zero", 32'(hours + minutes + seconds), 0);

    // Simultaneous tick and sec adjust at seconds == 10
    do_reset();
    repeat (10) pulse(1, "sim_pre");
    tick_1hz = 1'b1; sec_adj = 1'b1;
    m_apply(0); m_apply(1);
    @(posedge clk); #1;
    tick_1hz = 1'b0; sec_adj = 1'b0;
    @(posedge clk); #1;
    pop_cmp("sim_tick");
    check("sim_ovr1", 32'(evt_overrun), 0);
    @(posedge clk); #1;
    pop_cmp("sim_sec");
    check("sim_sec12", 32'(seconds), 12);
    check("sim_ovr2", 32'(evt_overrun), 0);

    // Alarm adjust wrap
    do_reset();
    repeat (6) pulse(4, "al6");
    check("al6_time", 32'(al_hours * 100 + al_minutes), 100);
    pulse(4, "al7");
    check("al7_time", 32'(al_hours * 100 + al_minutes), 110);

    // Alarm ring, auto-silence, re-arm
    do_reset();
    pulse(4, "ring_al");
    pulse(5, "ring_arm");
    check("arm_alon", 32'(al_on), 1);
    check("arm_buz", 32'(buzzer_en), 0);
    repeat (10) pulse(2, "ring_m");
    check("ring_lat_buz", 32'(buzzer_en), 0);
    @(posedge clk); #1;
    check("ring_buz", 32'(buzzer_en), 1);
    check("ring_alon", 32'(al_on), 1);
    repeat (59) pulse(0, "ring_t");
    check("ring59_buz", 32'(buzzer_en), 1);
    pulse(0, "ring_t60");
    @(posedge clk); #1;
    check("sil_buz", 32'(buzzer_en), 0);
    check("sil_alon", 32'(al_on), 1);
    check("sil_state", 32'(dut.state), 32'(AL_SILENCED));
    @(posedge clk); #1;
    check("rearm_state", 32'(dut.state), 32'(AL_ARMED));
    repeat (5) @(posedge clk);
    #1;
    check("norering_buz", 32'(buzzer_en), 0);
    check("norering_alon", 32'(al_on), 1);

    // Overrun with TICK continuously pending
    do_reset();
    ov_cnt = 0;
    tick_1hz = 1'b1;
    @(posedge clk); #1;
    sec_adj = 1'b1;
    @(posedge clk); #1;
    sec_adj = 1'b0;
    check("ovr_first", 32'(evt_overrun), 0);
    @(posedge clk); #1;
    sec_adj = 1'b1;
    check("ovr_gap", 32'(evt_overrun), 0);
    @(posedge clk); #1;
    sec_adj = 1'b0;
    check("ovr_pulse", 32'(evt_overrun), 1);
    for (int i = 0; i < 6; i++) begin
      if (evt_overrun) ov_cnt++;
      @(posedge clk); #1;
    end
    tick_1hz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ovr_once", 32'(ov_cnt), 1);

    // Reset in mid-ring drops the buzzer without a clock edge
    do_reset();
    pulse(5, "mr_arm");
    @(posedge clk); #1;
    check("mr_buz_on", 32'(buzzer_en), 1);
    #3 reset_n = 1'b0;
    #1;
    check("mr_buz_off", 32'(buzzer_en), 0);
    check("mr_alon_off", 32'(al_on), 0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    check("mr_post_buz", 32'(buzzer_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
